nios_lab_debug_jtag_host: RTL and testbench

Host-side driver for the Nios II debug-slave virtual-JTAG interface. It turns a system-side command (IR value plus DR payload) into a timed vji_* sequence: tck generation, UIR/CDR/SDR/UDR/RTI strobes and LSB-first TDI shifting. It captures TDO into a response word. The block sits in the simulation/bring-up harness in place of sld_virtual_jtag_basic and drives the debug slave's tck-side inputs.

---
 rtl/nios_lab_debug_jtag_pkg.sv | 23 ++
 rtl/nios_lab_debug_jtag_tckgen.sv | 46 ++++
 rtl/nios_lab_debug_jtag_host.sv | 169 ++++++++++++++++
 tb/tb_nios_lab_debug_jtag_host.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/nios_lab_debug_jtag_pkg.sv
// Shared types and constants for the Nios II debug-slave virtual-JTAG host.
package nios_lab_debug_jtag_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SDR,
    ST_UDR,
    ST_RTI,
    ST_DONE
  } state_e;

  // Instruction encodings understood by the debug slave
  localparam logic [1:0] IR_OCIMEM = 2'b00;
  localparam logic [1:0] IR_TRACE  = 2'b01;
  localparam logic [1:0] IR_BREAK  = 2'b10;
  localparam logic [1:0] IR_ENABLE = 2'b11;

  // Width of the debug slave's sr/jdo register
  localparam int DR_WIDTH_DEF = 38;

endpackage

// File: rtl/nios_lab_debug_jtag_tckgen.sv
// Test-clock divider: one tck period is 2*TCK_DIV clk cycles, low phase first.
// period_start and sample_point both fire on the last clk of a period (the last
// cycle of the high phase): anything registered on that edge changes together
// with the tck falling edge, and tdo is sampled just before it.
module nios_lab_debug_jtag_tckgen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic tck,
  output logic period_start,
  output logic sample_point
);

  localparam int PER = 2 * TCK_DIV;
  localparam int CW  = $clog2(PER);
  localparam logic [CW-1:0] LAST = CW'(PER - 1);
  localparam logic [CW-1:0] HALF = CW'(TCK_DIV);

  logic [CW-1:0] div_q, div_d;
  logic          tck_q, tck_d;

  // Divider advances only while a scan runs; tck is decoded from the next count
  always_comb begin
    div_d = '0;
    if (run && (div_q != LAST)) div_d = div_q + 1'b1;
    tck_d = run && (div_d >= HALF);
  end

  // Divider and tck registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q <= '0;
      tck_q <= 1'b0;
    end else begin
      div_q <= div_d;
      tck_q <= tck_d;
    end
  end

  assign tck          = tck_q;
  assign period_start = run && (div_q == LAST);
  assign sample_point = run && (div_q == LAST);

endmodule

// File: rtl/nios_lab_debug_jtag_host.sv
// Host-side virtual-JTAG driver for the Nios II debug slave: sequences
// UIR/CDR/SDR/UDR/RTI around one DR scan and returns the captured TDO word.
// Optional IR cache (skips UIR on a repeated instruction):
//   NIOS_LAB_DEBUG_JTAG_IR_CACHE_EN
module nios_lab_debug_jtag_host
  import nios_lab_debug_jtag_pkg::*;
#(
  parameter int DR_WIDTH = DR_WIDTH_DEF,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int BW = $clog2(DR_WIDTH + 1);

  state_e                state_q, state_d;
  logic [IR_WIDTH-1:0]   ir_q, ir_d;
  logic [DR_WIDTH-1:0]   shift_q, shift_d;
  logic [DR_WIDTH-1:0]   cap_q, cap_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DR_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  uir_q, cdr_q, sdr_q, udr_q, rti_q, tdi_q;
  logic                  uir_d, cdr_d, sdr_d, udr_d, rti_d, tdi_d;
`ifdef NIOS_LAB_DEBUG_JTAG_IR_CACHE_EN
  logic                  cache_vld_q, cache_vld_d;
`endif
  logic                  run, period_start, sample_point;

  assign run = (state_q != ST_IDLE) && (state_q != ST_DONE);

  nios_lab_debug_jtag_tckgen #(
    .TCK_DIV (TCK_DIV)
  ) u_tckgen (
    .clk          (clk),
    .reset_n      (reset_n),
    .run          (run),
    .tck          (vji_tck),
    .period_start (period_start),
    .sample_point (sample_point)
  );

  // Next-state, shift/capture datapath and registered-output decode
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    shift_d = shift_q;
    cap_d   = cap_q;
    bit_d   = bit_q;
`ifdef NIOS_LAB_DEBUG_JTAG_IR_CACHE_EN
    cache_vld_d = cache_vld_q;
`endif
    case (state_q)
      ST_IDLE: if (cmd_valid) begin
        // ir_q is what the slave sees, so loading it here makes it appear with UIR
        ir_d    = cmd_ir;
        shift_d = cmd_data;
        state_d = ST_UIR;
`ifdef NIOS_LAB_DEBUG_JTAG_IR_CACHE_EN
        if (cache_vld_q && (cmd_ir == ir_q)) state_d = ST_CDR;
`endif
      end
      ST_UIR: if (period_start) begin
        state_d = ST_CDR;
`ifdef NIOS_LAB_DEBUG_JTAG_IR_CACHE_EN
        cache_vld_d = 1'b1;
`endif
      end
      ST_CDR: if (period_start) begin
        state_d = ST_SDR;
        bit_d   = '0;
      end
      ST_SDR: if (sample_point) begin
        cap_d              = cap_q >> 1;
        cap_d[DR_WIDTH-1]  = vji_tdo;
        shift_d            = shift_q >> 1;
        bit_d              = bit_q + 1'b1;
        if (bit_q == BW'(DR_WIDTH - 1)) state_d = ST_UDR;
      end
      ST_UDR:  if (period_start) state_d = ST_RTI;
      ST_RTI:  if (period_start) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    uir_d       = (state_d == ST_UIR);
    cdr_d       = (state_d == ST_CDR);
    sdr_d       = (state_d == ST_SDR);
    udr_d       = (state_d == ST_UDR);
    rti_d       = (state_d == ST_RTI);
    tdi_d       = (state_d == ST_SDR) && shift_d[0];
    rsp_valid_d = (state_d == ST_DONE);
    rsp_data_d  = rsp_valid_d ? cap_d : rsp_data_q;
  end

  // FSM state and registered control outputs; reset aborts any scan in flight
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ir_q        <= '0;
      bit_q       <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      uir_q       <= 1'b0;
      cdr_q       <= 1'b0;
      sdr_q       <= 1'b0;
      udr_q       <= 1'b0;
      rti_q       <= 1'b0;
      tdi_q       <= 1'b0;
`ifdef NIOS_LAB_DEBUG_JTAG_IR_CACHE_EN
      cache_vld_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      bit_q       <= bit_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
      uir_q       <= uir_d;
      cdr_q       <= cdr_d;
      sdr_q       <= sdr_d;
      udr_q       <= udr_d;
      rti_q       <= rti_d;
      tdi_q       <= tdi_d;
`ifdef NIOS_LAB_DEBUG_JTAG_IR_CACHE_EN
      cache_vld_q <= cache_vld_d;
`endif
    end
  end

  // Payload and capture shift registers carry data only, so they are not reset
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    cap_q   <= cap_d;
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign vji_tdi   = tdi_q;
  assign vji_ir_in = ir_q;
  assign vji_uir   = uir_q;
  assign vji_cdr   = cdr_q;
  assign vji_sdr   = sdr_q;
  assign vji_udr   = udr_q;
  assign vji_rti   = rti_q;

endmodule

// File: tb/tb_nios_lab_debug_jtag_host.sv
// Directed bench for nios_lab_debug_jtag_host: a DR_WIDTH=38/TCK_DIV=2 instance
// and a DR_WIDTH=8/TCK_DIV=1 instance share one clock.
module tb_nios_lab_debug_jtag_host;

  localparam int DW = 38;

  localparam int M_UIR = 0, M_CDR = 1, M_SDR = 2, M_UDR = 3, M_RTI = 4;
  localparam int M_RSP = 5, M_MULTI = 6, M_TDI = 7, M_BUSYRDY = 8, M_TCK8 = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, cmd_valid, cmd_ready, rsp_valid;
  logic [1:0]    cmd_ir, ir_in;
  logic [DW-1:0] cmd_data, rsp_data;
  logic          tck, tdi, tdo, uir, cdr, sdr, udr, rti;
  logic          loop_en, tdo_val;

  logic          c8_valid, c8_ready, r8_valid;
  logic [1:0]    c8_ir, ir8;
  logic [7:0]    c8_data, r8_data;
  logic          tck8, tdi8, uir8, cdr8, sdr8, udr8, rti8;

  assign tdo = loop_en ? tdi : tdo_val;

  nios_lab_debug_jtag_host #(.DR_WIDTH(DW), .IR_WIDTH(2), .TCK_DIV(2)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .vji_tck(tck), .vji_tdi(tdi), .vji_tdo(tdo), .vji_ir_in(ir_in),
    .vji_uir(uir), .vji_cdr(cdr), .vji_sdr(sdr), .vji_udr(udr), .vji_rti(rti)
  );

  nios_lab_debug_jtag_host #(.DR_WIDTH(8), .IR_WIDTH(2), .TCK_DIV(1)) dut8 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(c8_valid), .cmd_ready(c8_ready),
    .cmd_ir(c8_ir), .cmd_data(c8_data), .rsp_valid(r8_valid), .rsp_data(r8_data),
    .vji_tck(tck8), .vji_tdi(tdi8), .vji_tdo(tdi8), .vji_ir_in(ir8),
    .vji_uir(uir8), .vji_cdr(cdr8), .vji_sdr(sdr8), .vji_udr(udr8), .vji_rti(rti8)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_acc = 0;
  int cnt [10] = '{default: 0};
  int base [10] = '{default: 0};

  always @(posedge clk) cyc <= cyc + 1;

  // Free-running event counters; the stimulus snapshots them and checks deltas
  always @(negedge clk) begin
    cnt[M_UIR]     <= cnt[M_UIR] + int'(uir);
    cnt[M_CDR]     <= cnt[M_CDR] + int'(cdr);
    cnt[M_SDR]     <= cnt[M_SDR] + int'(sdr);
    cnt[M_UDR]     <= cnt[M_UDR] + int'(udr);
    cnt[M_RTI]     <= cnt[M_RTI] + int'(rti);
    cnt[M_RSP]     <= cnt[M_RSP] + int'(rsp_valid);
    cnt[M_MULTI]   <= cnt[M_MULTI] + int'((int'(uir) + int'(cdr) + int'(sdr) + int'(udr) + int'(rti)) > 1);
    cnt[M_TDI]     <= cnt[M_TDI] + int'(tdi && !sdr);
    cnt[M_BUSYRDY] <= cnt[M_BUSYRDY] + int'(cmd_ready && (uir || cdr || sdr || udr || rti || rsp_valid));
    cnt[M_TCK8]    <= cnt[M_TCK8] + int'(tck8);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    for (int i = 0; i < 10; i++) base[i] = cnt[i];
  endtask

  function automatic int delta(input int i);
    return cnt[i] - base[i];
  endfunction

  // Present a command for one cycle (or keep it asserted when hold=1)
  task automatic send(input logic [1:0] ir, input logic [DW-1:0] data, input bit hold);
    @(posedge clk); #1;
    snap();
    cmd_ir    = ir;
    cmd_data  = data;
    cmd_valid = 1'b1;
    @(negedge clk);
    n_acc = cyc;
    if (!hold) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp(output int at, output logic [DW-1:0] d);
    at = -1;
    d  = '0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        at = cyc;
        d  = rsp_data;
        break;
      end
    end
  endtask

  int            r, r8, n8, exp_lat2, exp_uir2;
  logic [DW-1:0] d;

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_ir = '0; cmd_data = '0;
    loop_en = 1'b1; tdo_val = 1'b0;
    c8_valid = 1'b0; c8_ir = '0; c8_data = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_outputs", {rsp_valid, tck, tdi, uir, cdr, sdr, udr, rti}, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_ir_in", ir_in, 0);
    check("rst_dut8_ready_rsp", {c8_ready, r8_valid, tck8}, 3'b100);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Loopback scan, BREAK instruction
    send(2'b10, 38'h2A_5A5A_5A5A, 1'b0);
    wait_rsp(r, d);
    check("loop_latency", r - n_acc, 169);
    check("loop_rsp_data", d, 38'h2A_5A5A_5A5A);
    check("loop_ir_in", ir_in, 2'b10);
    repeat (2) @(negedge clk);
    check("loop_uir_cycles", delta(M_UIR), 4);
    check("loop_cdr_cycles", delta(M_CDR), 4);
    check("loop_sdr_cycles", delta(M_SDR), 152);
    check("loop_udr_cycles", delta(M_UDR), 4);
    check("loop_rti_cycles", delta(M_RTI), 4);
    check("loop_rsp_pulses", delta(M_RSP), 1);
    check("loop_multi_strobe", delta(M_MULTI), 0);
    check("loop_tdi_outside_sdr", delta(M_TDI), 0);

    // Constant TDO
    loop_en = 1'b0; tdo_val = 1'b1;
    send(2'b00, 38'h01_2345_6789, 1'b0);
    wait_rsp(r, d);
    check("tdo1_rsp_data", d, 38'h3F_FFFF_FFFF);
    tdo_val = 1'b0;
    send(2'b11, 38'h3F_FFFF_FFFF, 1'b0);
    wait_rsp(r, d);
    check("tdo0_rsp_data", d, 38'h0);
    loop_en = 1'b1;

    // Backpressure: valid held, payload changes while busy
    send(2'b01, 38'h00_DEAD_BEEF, 1'b1);
    @(posedge clk); #1;
    cmd_ir   = 2'b10;
    cmd_data = 38'h3C_0F0F_1234;
    wait_rsp(r, d);
    check("bp_first_rsp", d, 38'h00_DEAD_BEEF);
    @(negedge clk);
    check("bp_ready_after_done", cmd_ready, 1);
    n_acc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_rsp(r, d);
    check("bp_second_latency", r - n_acc, 169);
    check("bp_second_rsp", d, 38'h3C_0F0F_1234);
    repeat (2) @(negedge clk);
    check("bp_ready_while_busy", delta(M_BUSYRDY), 0);
    check("bp_rsp_pulses", delta(M_RSP), 2);

    // Reset in the middle of SDR (around bit 10)
    send(2'b00, 38'h15_5555_5555, 1'b0);
    repeat (50) @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst_outputs", {rsp_valid, tck, tdi, uir, cdr, sdr, udr, rti}, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    repeat (250) @(negedge clk);
    check("midrst_no_rsp", delta(M_RSP), 0);

    // IR cache: two commands with the same instruction after reset
`ifdef NIOS_LAB_DEBUG_JTAG_IR_CACHE_EN
    exp_lat2 = 165; exp_uir2 = 0;
`else
    exp_lat2 = 169; exp_uir2 = 4;
`endif
    send(2'b01, 38'h12_3456_789A, 1'b0);
    wait_rsp(r, d);
    check("cache_first_latency", r - n_acc, 169);
    send(2'b01, 38'h2B_CDEF_0123, 1'b0);
    wait_rsp(r, d);
    check("cache_second_latency", r - n_acc, exp_lat2);
    check("cache_second_rsp", d, 38'h2B_CDEF_0123);
    repeat (2) @(negedge clk);
    check("cache_second_uir_cycles", delta(M_UIR), exp_uir2);

    // DR_WIDTH=8, TCK_DIV=1 loopback
    @(posedge clk); #1;
    snap();
    c8_ir = 2'b11; c8_data = 8'hC3; c8_valid = 1'b1;
    @(negedge clk);
    n8 = cyc;
    check("d8_ready_at_accept", c8_ready, 1);
    @(posedge clk); #1;
    c8_valid = 1'b0;
    r8 = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (r8_valid) begin
        r8 = cyc;
        break;
      end
    end
    check("d8_latency", r8 - n8, 25);
    check("d8_rsp_data", r8_data, 8'hC3);
    repeat (2) @(negedge clk);
    check("d8_tck_high_cycles", delta(M_TCK8), 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
